// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared definitions for the system-bus arbiter.
//   REQ_SPI / REQ_DMEM / REQ_DMA : requester indices on i_req / o_gnt
//   arb_state_e                  : arbiter FSM states
package sys_bus_pkg;

    localparam int unsigned REQ_SPI  = 0;
    localparam int unsigned REQ_DMEM = 1;
    localparam int unsigned REQ_DMA  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational rotated-priority search.
// Finds the first asserted request strictly after 'last', wrapping to 0.
//   req    : level requests, one bit per master
//   last   : index of the most recent winner
//   valid  : high when any request is asserted
//   winner : selected index (meaningful only when valid)
module rr_priority_pick #(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] winner
);

    localparam int unsigned IW = $clog2(NREQ);

    logic          hi_valid;
    logic          lo_valid;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Two ascending scans replace a modulo rotation: the lowest request above
    // 'last' wins; otherwise the lowest request at or below 'last' wins.
    always_comb begin
        hi_valid = 1'b0;
        lo_valid = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (req[j]) begin
                if (j > 32'(last)) begin
                    if (!hi_valid) begin
                        hi_valid = 1'b1;
                        hi_idx   = IW'(j);
                    end
                end else begin
                    if (!lo_valid) begin
                        lo_valid = 1'b1;
                        lo_idx   = IW'(j);
                    end
                end
            end
        end
    end

    assign valid  = hi_valid | lo_valid;
    assign winner = hi_valid ? hi_idx : lo_idx;

endmodule

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: registered, non-preemptive round-robin arbiter for the
// system bus (SPI loader, core data port, PIM DMA) with a hold-time watchdog.
//   i_clk      : system clock
//   i_rst      : asynchronous active-high reset
//   i_req      : level request per master, held for the whole transaction
//   o_gnt      : one-hot-or-zero registered grant
//   o_owner    : current / most recent owner index (bus mux select)
//   o_busy     : any grant asserted
//   o_hold_cnt : cycles the current grant has been held, saturating
//   o_timeout  : one-cycle status pulse when hold count reaches HOLD_MAX
//                while another master is waiting
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned HOLD_MAX = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NREQ-1:0]               i_req,
    output logic [NREQ-1:0]               o_gnt,
    output logic [$clog2(NREQ)-1:0]       o_owner,
    output logic                          o_busy,
    output logic [$clog2(HOLD_MAX+1)-1:0] o_hold_cnt,
    output logic                          o_timeout
);

    localparam int unsigned   IW       = $clog2(NREQ);
    localparam int unsigned   CW       = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_SAT = CW'(HOLD_MAX);
    localparam logic [CW-1:0] HOLD_PRE = CW'(HOLD_MAX - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    arb_state_e    state;
    logic [IW-1:0] last;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          owner_req;
    logic          others_req;

    rr_priority_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (i_req),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    assign owner_req  = i_req[o_owner];
    // o_gnt is one-hot on the owner during GRANT, so masking it leaves
    // exactly the competing requests.
    assign others_req = |(i_req & ~o_gnt);
    assign o_busy     = |o_gnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            last       <= LAST_RST;
            o_gnt      <= '0;
            o_owner    <= '0;
            o_hold_cnt <= '0;
            o_timeout  <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= GRANT;
                        o_gnt      <= NREQ'(1) << pick_idx;
                        o_owner    <= pick_idx;
                        last       <= pick_idx;
                        o_hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (owner_req) begin
                        if (o_hold_cnt != HOLD_SAT) begin
                            o_hold_cnt <= o_hold_cnt + CW'(1);
                            // Fires only on the step into saturation, so at
                            // most once per grant.
                            if (o_hold_cnt == HOLD_PRE && others_req) begin
                                o_timeout <= 1'b1;
                            end
                        end
                    end else begin
                        state <= TURN;
                        o_gnt <= '0;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    o_gnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
module tb_sys_bus_arbiter;
    import sys_bus_pkg::*;

    localparam int unsigned NREQ     = 3;
    localparam int unsigned HOLD_MAX = 8;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic [3:0] hold_cnt;
    logic       timeout;

    int checks;
    int failures;

    sys_bus_arbiter #(
        .NREQ     (NREQ),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .o_gnt      (gnt),
        .o_owner    (owner),
        .o_busy     (busy),
        .o_hold_cnt (hold_cnt),
        .o_timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0 || owner !== 2'd0 ||
            hold_cnt !== 4'd0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b busy=%b owner=%0d hold=%0d to=%b exp 000 0 0 0 0",
                     gnt, busy, owner, hold_cnt, timeout);
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        req = 3'b001;
        tick();
        checks++;
        if (gnt !== 3'b001 || owner !== 2'd0 || busy !== 1'b1 || hold_cnt !== 4'd0) begin
            failures++;
            $display("FAIL single_grant got gnt=%b owner=%0d busy=%b hold=%0d exp 001 0 1 0",
                     gnt, owner, busy, hold_cnt);
        end
        tick();
        tick();
        tick();
        checks++;
        if (hold_cnt !== 4'd3 || gnt !== 3'b001) begin
            failures++;
            $display("FAIL single_hold got hold=%0d gnt=%b exp 3 001", hold_cnt, gnt);
        end
        req = 3'b000;
        tick();
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0 || owner !== 2'd0 || hold_cnt !== 4'd3) begin
            failures++;
            $display("FAIL single_release got gnt=%b busy=%b owner=%0d hold=%0d exp 000 0 0 3",
                     gnt, busy, owner, hold_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_order [4];
        exp_order[0] = 2'd0;
        exp_order[1] = 2'd1;
        exp_order[2] = 2'd2;
        exp_order[3] = 2'd0;
        do_reset();
        req = 3'b111;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (owner !== exp_order[k] || gnt !== (3'b001 << exp_order[k]) || hold_cnt !== 4'd0) begin
                failures++;
                $display("FAIL rr_grant%0d got owner=%0d gnt=%b hold=%0d exp owner=%0d",
                         k, owner, gnt, hold_cnt, exp_order[k]);
            end
            tick();
            tick();
            tick();
            req = 3'b111 & ~(3'b001 << exp_order[k]);
            tick();
            checks++;
            if (gnt !== 3'b000 || owner !== exp_order[k]) begin
                failures++;
                $display("FAIL rr_turn%0d got gnt=%b owner=%0d exp 000 owner=%0d",
                         k, gnt, owner, exp_order[k]);
            end
            req = 3'b111;
            tick();
            checks++;
            if (gnt !== 3'b000) begin
                failures++;
                $display("FAIL rr_idle%0d got gnt=%b exp 000", k, gnt);
            end
            tick();
        end
    endtask

    task automatic test_watchdog();
        int pulses;
        pulses = 0;
        do_reset();
        req = 3'b010;
        tick();
        req = 3'b011;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (timeout === 1'b1) pulses++;
            checks++;
            if (hold_cnt !== ((i < 8) ? 4'(i) : 4'd8) || timeout !== (i == 8) || gnt !== 3'b010) begin
                failures++;
                $display("FAIL wd_step%0d got hold=%0d to=%b gnt=%b exp hold=%0d to=%b gnt=010",
                         i, hold_cnt, timeout, gnt, (i < 8) ? i : 8, (i == 8));
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL wd_pulse_count got %0d exp 1", pulses);
        end
        req = 3'b001;
        tick();
        checks++;
        if (gnt !== 3'b000 || hold_cnt !== 4'd8 || owner !== 2'd1) begin
            failures++;
            $display("FAIL wd_release got gnt=%b hold=%0d owner=%0d exp 000 8 1", gnt, hold_cnt, owner);
        end
        tick();
        tick();
        checks++;
        if (gnt !== 3'b001 || owner !== 2'(REQ_SPI) || hold_cnt !== 4'd0) begin
            failures++;
            $display("FAIL wd_next_owner got gnt=%b owner=%0d hold=%0d exp 001 0 0", gnt, owner, hold_cnt);
        end
    endtask

    task automatic test_watchdog_quiet();
        int pulses;
        pulses = 0;
        do_reset();
        req = 3'b010;
        tick();
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (timeout === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL quiet_no_timeout got pulses=%0d exp 0", pulses);
        end
        checks++;
        if (hold_cnt !== 4'd8 || gnt !== 3'b010) begin
            failures++;
            $display("FAIL quiet_saturate got hold=%0d gnt=%b exp 8 010", hold_cnt, gnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 3'b010;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0 || owner !== 2'd0 || hold_cnt !== 4'd0) begin
            failures++;
            $display("FAIL async_reset got gnt=%b busy=%b owner=%0d hold=%0d exp 000 0 0 0",
                     gnt, busy, owner, hold_cnt);
        end
        req = 3'b000;
        tick();
        #2;
        rst = 1'b0;
        req = 3'b110;
        tick();
        checks++;
        if (gnt !== 3'b010 || owner !== 2'(REQ_DMEM)) begin
            failures++;
            $display("FAIL post_reset_rr got gnt=%b owner=%0d exp 010 1", gnt, owner);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 3'b001;
        tick();
        tick();
        req = 3'b100;
        tick();
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_turn got gnt=%b busy=%b exp 000 0", gnt, busy);
        end
        tick();
        checks++;
        if (gnt !== 3'b000) begin
            failures++;
            $display("FAIL b2b_idle got gnt=%b exp 000", gnt);
        end
        tick();
        checks++;
        if (gnt !== 3'b100 || owner !== 2'(REQ_DMA) || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_dma got gnt=%b owner=%0d busy=%b exp 100 2 1", gnt, owner, busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = '0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_watchdog();
        test_watchdog_quiet();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
